// File: rtl/comm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comm_ctrl
// Brief    : Sequences the Fibonacci/timer generators into the buffer wrapper,
//            throttles on full, drains on stop, reports the active source.
// Revision : 1.0 - initial release
// ============================================================================
module comm_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              stop_f_t,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_out,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] t_out,
    input  logic              buffer_full,
    input  logic              buffer_empty,
    input  logic              data_2_valid,
    output logic              f_en,
    output logic              t_en,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic [1:0]        modules,
    output logic [15:0]       word_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMM_F    = 3'd1,
        S_COMM_T    = 3'd2,
        S_BUF_EMPTY = 3'd3,
        S_WAIT_F    = 3'd4,
        S_WAIT_T    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_start_f_q;
    logic              r_start_t_q;
    logic              r_stop_q;
    logic              r_data_1_en;
    logic [DATA_W-1:0] r_data_1;
    logic [15:0]       r_word_cnt;

    logic              w_start_f_pls;
    logic              w_start_t_pls;
    logic              w_stop_pls;
    logic              w_f_wr;
    logic              w_t_wr;
    logic              w_session_start;

    assign w_start_f_pls = start_f  & ~r_start_f_q;
    assign w_start_t_pls = start_t  & ~r_start_t_q;
    assign w_stop_pls    = stop_f_t & ~r_stop_q;

    // Enables drop in the same cycle full rises so no word is produced into a full buffer
    assign f_en   = (r_state == S_COMM_F) & ~buffer_full;
    assign t_en   = (r_state == S_COMM_T) & ~buffer_full;
    assign w_f_wr = f_en & f_valid;
    assign w_t_wr = t_en & t_valid;

    assign w_session_start = (r_state == S_IDLE) & (w_start_f_pls | w_start_t_pls);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_f_pls)      w_next_state = S_COMM_F;
                else if (w_start_t_pls) w_next_state = S_COMM_T;
            end
            S_COMM_F: begin
                if (w_stop_pls)       w_next_state = S_BUF_EMPTY;
                else if (buffer_full) w_next_state = S_WAIT_F;
            end
            S_COMM_T: begin
                if (w_stop_pls)       w_next_state = S_BUF_EMPTY;
                else if (buffer_full) w_next_state = S_WAIT_T;
            end
            S_WAIT_F: begin
                if (w_stop_pls)        w_next_state = S_BUF_EMPTY;
                else if (!buffer_full) w_next_state = S_COMM_F;
            end
            S_WAIT_T: begin
                if (w_stop_pls)        w_next_state = S_BUF_EMPTY;
                else if (!buffer_full) w_next_state = S_COMM_T;
            end
            S_BUF_EMPTY: begin
                if (buffer_empty && !data_2_valid) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        modules = 2'b00;
        case (r_state)
            S_COMM_F, S_WAIT_F: modules = 2'b01;
            S_COMM_T, S_WAIT_T: modules = 2'b10;
            S_BUF_EMPTY:        modules = 2'b11;
            default:            modules = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_f_q <= 1'b0;
            r_start_t_q <= 1'b0;
            r_stop_q    <= 1'b0;
            r_data_1_en <= 1'b0;
            r_data_1    <= '0;
            r_word_cnt  <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_start_f_q <= start_f;
            r_start_t_q <= start_t;
            r_stop_q    <= stop_f_t;
            r_data_1_en <= w_f_wr | w_t_wr;
            if (w_f_wr)      r_data_1 <= f_out;
            else if (w_t_wr) r_data_1 <= t_out;
            // Counter tracks strobes already issued, so it trails data_1_en by one edge
            if (w_session_start)  r_word_cnt <= 16'd0;
            else if (r_data_1_en) r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign data_1_en = r_data_1_en;
    assign data_1    = r_data_1;
    assign word_cnt  = r_word_cnt;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_comm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_comm_ctrl
// Brief    : Self-checking bench for comm_ctrl: directed vector table, random
//            stimulus against a session-level model, counter wrap, async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_f = 1'b0, start_t = 1'b0, stop_f_t = 1'b0;
    logic        f_valid = 1'b0, t_valid = 1'b0;
    logic [15:0] f_out = '0, t_out = '0;
    logic        buffer_full = 1'b0, buffer_empty = 1'b0, data_2_valid = 1'b0;
    logic        f_en, t_en, data_1_en;
    logic [15:0] data_1, word_cnt;
    logic [1:0]  modules;
    logic [2:0]  state;

    int n_chk = 0;
    int n_err = 0;

    comm_ctrl #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .start_f(start_f), .start_t(start_t), .stop_f_t(stop_f_t),
        .f_valid(f_valid), .f_out(f_out), .t_valid(t_valid), .t_out(t_out),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
        .f_en(f_en), .t_en(t_en), .data_1_en(data_1_en), .data_1(data_1),
        .modules(modules), .word_cnt(word_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        start_f = 0; start_t = 0; stop_f_t = 0; f_valid = 0; t_valid = 0;
        f_out = '0; t_out = '0; buffer_full = 0; buffer_empty = 0; data_2_valid = 0;
    endtask

    // Returns at a falling edge with reset just released
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Directed vectors: inputs held for one cycle, expected outputs seen in that cycle
    typedef struct {
        int sf, st, sp, fv, fo, tv, to, full, emp, d2v;
        int es, ef, et, em, ed, e1, ec;
    } vec_t;
    vec_t tbl[28];

    // Session-level reference model: which source runs, whether it is paused or draining
    int m_src, m_paused, m_drain, m_en, m_data, m_cnt, p_sf, p_st, p_sp;

    task automatic model_reset();
        m_src = 0; m_paused = 0; m_drain = 0; m_en = 0; m_data = 0; m_cnt = 0;
        p_sf = 0; p_st = 0; p_sp = 0;
    endtask

    function automatic int model_state();
        if (m_drain != 0) return 3;
        if (m_src == 1)   return (m_paused != 0) ? 4 : 1;
        if (m_src == 2)   return (m_paused != 0) ? 5 : 2;
        return 0;
    endfunction

    function automatic int model_fen();
        return (m_src == 1 && m_paused == 0 && m_drain == 0 && !buffer_full) ? 1 : 0;
    endfunction

    function automatic int model_ten();
        return (m_src == 2 && m_paused == 0 && m_drain == 0 && !buffer_full) ? 1 : 0;
    endfunction

    task automatic model_step();
        int pf, pt, ps, ef, et, wr;
        pf = (start_f  && p_sf == 0) ? 1 : 0;
        pt = (start_t  && p_st == 0) ? 1 : 0;
        ps = (stop_f_t && p_sp == 0) ? 1 : 0;
        ef = model_fen();
        et = model_ten();
        wr = ((ef != 0 && f_valid) || (et != 0 && t_valid)) ? 1 : 0;
        if (m_drain == 0 && m_src == 0 && (pf != 0 || pt != 0)) m_cnt = 0;
        else if (m_en != 0) m_cnt = (m_cnt + 1) % 65536;
        if (wr != 0) m_data = (ef != 0) ? int'(f_out) : int'(t_out);
        m_en = wr;
        if (m_drain != 0) begin
            if (buffer_empty && !data_2_valid) m_drain = 0;
        end else if (m_src == 0) begin
            if (pf != 0)      begin m_src = 1; m_paused = 0; end
            else if (pt != 0) begin m_src = 2; m_paused = 0; end
        end else if (ps != 0) begin
            m_drain = 1; m_src = 0; m_paused = 0;
        end else begin
            m_paused = buffer_full ? 1 : 0;
        end
        p_sf = start_f ? 1 : 0;
        p_st = start_t ? 1 : 0;
        p_sp = stop_f_t ? 1 : 0;
    endtask

    initial begin
        //             sf st sp fv fo  tv to  fu em dv   es ef et em ed e1  ec
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0};
        tbl[1]  = '{1, 0, 0, 1, 1,  0, 0,  0, 0, 0,   1, 1, 0, 1, 0, 0,  0};
        tbl[2]  = '{1, 0, 0, 1, 1,  0, 0,  0, 0, 0,   1, 1, 0, 1, 1, 1,  0};
        tbl[3]  = '{0, 0, 0, 1, 2,  0, 0,  0, 0, 0,   1, 1, 0, 1, 1, 1,  1};
        tbl[4]  = '{0, 0, 0, 1, 3,  0, 0,  0, 0, 0,   1, 1, 0, 1, 1, 2,  2};
        tbl[5]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0, 0,   1, 1, 0, 1, 1, 3,  3};
        tbl[6]  = '{0, 0, 0, 1, 5,  0, 0,  1, 0, 0,   1, 0, 0, 1, 0, 3,  4};
        tbl[7]  = '{0, 0, 0, 1, 5,  0, 0,  1, 0, 0,   4, 0, 0, 1, 0, 3,  4};
        tbl[8]  = '{0, 0, 0, 1, 5,  0, 0,  0, 0, 0,   4, 0, 0, 1, 0, 3,  4};
        tbl[9]  = '{0, 0, 0, 1, 8,  0, 0,  0, 0, 0,   1, 1, 0, 1, 0, 3,  4};
        tbl[10] = '{0, 0, 1, 1, 13, 0, 0,  1, 0, 0,   1, 0, 0, 1, 1, 8,  4};
        tbl[11] = '{1, 0, 1, 0, 0,  0, 0,  0, 1, 1,   3, 0, 0, 3, 0, 8,  5};
        tbl[12] = '{0, 0, 0, 0, 0,  0, 0,  0, 1, 0,   3, 0, 0, 3, 0, 8,  5};
        tbl[13] = '{1, 1, 0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 8,  5};
        tbl[14] = '{0, 0, 0, 0, 0,  1, 7,  0, 0, 0,   1, 1, 0, 1, 0, 8,  0};
        tbl[15] = '{0, 0, 1, 0, 0,  0, 0,  0, 0, 0,   1, 1, 0, 1, 0, 8,  0};
        tbl[16] = '{0, 0, 0, 0, 0,  0, 0,  0, 1, 0,   3, 0, 0, 3, 0, 8,  0};
        tbl[17] = '{0, 1, 0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 8,  0};
        tbl[18] = '{0, 0, 0, 0, 0,  1, 21, 0, 0, 0,   2, 0, 1, 2, 0, 8,  0};
        tbl[19] = '{0, 0, 0, 0, 0,  1, 34, 1, 0, 0,   2, 0, 0, 2, 1, 21, 0};
        tbl[20] = '{0, 0, 0, 0, 0,  0, 0,  1, 0, 0,   5, 0, 0, 2, 0, 21, 1};
        tbl[21] = '{0, 0, 0, 0, 0,  1, 34, 0, 0, 0,   5, 0, 0, 2, 0, 21, 1};
        tbl[22] = '{0, 0, 0, 0, 0,  1, 34, 0, 0, 0,   2, 0, 1, 2, 0, 21, 1};
        tbl[23] = '{0, 0, 0, 0, 0,  0, 0,  0, 0, 0,   2, 0, 1, 2, 1, 34, 1};
        tbl[24] = '{0, 0, 1, 0, 0,  0, 0,  0, 1, 0,   2, 0, 1, 2, 0, 34, 2};
        tbl[25] = '{0, 0, 0, 0, 0,  0, 0,  0, 1, 0,   3, 0, 0, 3, 0, 34, 2};
        tbl[26] = '{0, 0, 1, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 34, 2};
        tbl[27] = '{0, 0, 0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 34, 2};

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("reset_state",   int'(state),     0);
        chk("reset_modules", int'(modules),   0);
        chk("reset_f_en",    int'(f_en),      0);
        chk("reset_d1en",    int'(data_1_en), 0);
        chk("reset_cnt",     int'(word_cnt),  0);

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < 28; i++) begin
            start_f = tbl[i].sf[0]; start_t = tbl[i].st[0]; stop_f_t = tbl[i].sp[0];
            f_valid = tbl[i].fv[0]; f_out = tbl[i].fo[15:0];
            t_valid = tbl[i].tv[0]; t_out = tbl[i].to[15:0];
            buffer_full = tbl[i].full[0]; buffer_empty = tbl[i].emp[0];
            data_2_valid = tbl[i].d2v[0];
            #1;
            chk($sformatf("tbl%0d_state", i),   int'(state),     tbl[i].es);
            chk($sformatf("tbl%0d_f_en", i),    int'(f_en),      tbl[i].ef);
            chk($sformatf("tbl%0d_t_en", i),    int'(t_en),      tbl[i].et);
            chk($sformatf("tbl%0d_modules", i), int'(modules),   tbl[i].em);
            chk($sformatf("tbl%0d_d1en", i),    int'(data_1_en), tbl[i].ed);
            chk($sformatf("tbl%0d_data_1", i),  int'(data_1),    tbl[i].e1);
            chk($sformatf("tbl%0d_word_cnt", i), int'(word_cnt), tbl[i].ec);
            @(negedge clk);
        end

        // ---------------- randomized vs model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            start_f      = ($urandom_range(0, 3) == 0);
            start_t      = ($urandom_range(0, 3) == 0);
            stop_f_t     = ($urandom_range(0, 11) == 0);
            f_valid      = ($urandom_range(0, 1) == 0);
            t_valid      = ($urandom_range(0, 1) == 0);
            f_out        = 16'($urandom);
            t_out        = 16'($urandom);
            buffer_full  = ($urandom_range(0, 3) == 0);
            buffer_empty = ($urandom_range(0, 1) == 0);
            data_2_valid = ($urandom_range(0, 2) == 0);
            #1;
            chk("rnd_state",    int'(state),     model_state());
            chk("rnd_modules",  int'(modules),   (m_drain != 0) ? 3 : m_src);
            chk("rnd_f_en",     int'(f_en),      model_fen());
            chk("rnd_t_en",     int'(t_en),      model_ten());
            chk("rnd_d1en",     int'(data_1_en), m_en);
            chk("rnd_data_1",   int'(data_1),    m_data);
            chk("rnd_word_cnt", int'(word_cnt),  m_cnt);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        // ---------------- word counter wrap ----------------
        do_reset();
        start_f = 1; f_valid = 1; f_out = 16'h1234;
        @(posedge clk);
        #1 start_f = 0;
        repeat (65535) @(posedge clk);
        #1 chk("wrap_fffe", int'(word_cnt), 16'hFFFE);
        repeat (2) @(posedge clk);
        #1 chk("wrap_zero", int'(word_cnt), 0);
        @(posedge clk);
        #1 chk("wrap_one", int'(word_cnt), 1);
        @(negedge clk);
        f_valid = 0; stop_f_t = 1; buffer_empty = 1;
        @(posedge clk);
        #1 chk("wrap_drain_state", int'(state), 3);
        chk("wrap_drain_cnt", int'(word_cnt), 2);
        @(negedge clk);
        stop_f_t = 0;
        @(posedge clk);
        #1 chk("wrap_idle_state", int'(state), 0);
        chk("wrap_idle_cnt", int'(word_cnt), 2);
        @(negedge clk);
        start_t = 1;
        @(posedge clk);
        #1 chk("wrap_restart_state", int'(state), 2);
        chk("wrap_restart_cnt", int'(word_cnt), 0);
        @(negedge clk);
        start_t = 0;

        // ---------------- async reset in WAIT_F ----------------
        do_reset();
        start_f = 1; f_valid = 1; f_out = 16'h0055;
        @(posedge clk);
        #1 start_f = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        buffer_full = 1;
        @(posedge clk);
        #1 chk("ar_wait_state", int'(state), 4);
        chk("ar_wait_cnt", int'(word_cnt), 2);
        chk("ar_wait_data", int'(data_1), 16'h0055);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("ar_state",   int'(state),     0);
        chk("ar_modules", int'(modules),   0);
        chk("ar_f_en",    int'(f_en),      0);
        chk("ar_t_en",    int'(t_en),      0);
        chk("ar_d1en",    int'(data_1_en), 0);
        chk("ar_data_1",  int'(data_1),    0);
        chk("ar_cnt",     int'(word_cnt),  0);
        @(negedge clk);
        rst = 0; buffer_full = 0; f_valid = 0; stop_f_t = 1;
        @(posedge clk);
        #1 chk("ar_stop_idle", int'(state), 0);
        chk("ar_stop_modules", int'(modules), 0);
        @(negedge clk);
        stop_f_t = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comm_ctrl.md
# comm_ctrl

Communication controller that sequences the Fibonacci and timer generators into the dual-clock buffer wrapper. It edge-detects the operator buttons, selects one generator at a time, and throttles the generator on `buffer_full`. On stop it drains the buffer before returning to idle, and it reports the active source to the display manager. It sits in the `clk` domain between `fibonacci`/`timer` and `wrapper`, replacing the inline FSM in the top level.

## Interface
- `DATA_W`, 16, width of generator words and `data_1`
- `clk`  in  1  system clock (same `clk` that drives `fibonacci`, `timer` and `dm`)
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `start_f`  in  1  start-Fibonacci button level, synchronous to `clk`
- `start_t`  in  1  start-timer button level, synchronous to `clk`
- `stop_f_t`  in  1  stop button level, synchronous to `clk`
- `f_valid`  in  1  Fibonacci word valid
- `f_out`  in  DATA_W  Fibonacci word
- `t_valid`  in  1  timer word valid
- `t_out`  in  DATA_W  timer word
- `buffer_full`  in  1  wrapper full flag, already in the `clk` domain
- `buffer_empty`  in  1  wrapper empty flag
- `data_2_valid`  in  1  wrapper read-side word still valid
- `f_en`  out  1  Fibonacci enable (combinational decode of the state register)
- `t_en`  out  1  timer enable (combinational decode of the state register)
- `data_1_en`  out  1  buffer write strobe, registered
- `data_1`  out  DATA_W  buffer write data, registered
- `modules`  out  2  active source, to `dm`
- `word_cnt`  out  16  words written in the current session
- `state`  out  3  current state encoding, for debug

## Operation
- Button edge detect: each button has a `_q` register. A pulse is `btn & ~btn_q`. A held button produces exactly one pulse.
- States: IDLE=0, COMM_F=1, COMM_T=2, BUF_EMPTY=3, WAIT_F=4, WAIT_T=5. Codes 6 and 7 go to IDLE on the next clock.
- IDLE transitions:
  - start_f pulse → COMM_F.
  - Otherwise start_t pulse → COMM_T.
  - start_f has priority if both pulse in the same cycle.
  - A stop pulse is ignored in IDLE.
- COMM_x transitions:
  - Stop pulse → BUF_EMPTY.
  - Otherwise `buffer_full` → WAIT_x.
  - Otherwise stay.
  - Stop wins over full in the same cycle.
- WAIT_x transitions:
  - Stop pulse → BUF_EMPTY.
  - Otherwise `!buffer_full` → COMM_x.
- BUF_EMPTY: when `buffer_empty && !data_2_valid` → IDLE. Start pulses are ignored here.
- Enables:
  - `f_en = (state==COMM_F) & !buffer_full`.
  - `t_en = (state==COMM_T) & !buffer_full`.
  - Both are 0 in every other state, so a generator halts in the same cycle that full rises.
- Write path, each clock:
  - `data_1_en <= (f_en & f_valid) | (t_en & t_valid)`.
  - When the strobe is set, `data_1` loads the selected word (`f_out` or `t_out`); otherwise `data_1` holds.
- `modules` values:
  - 00 in IDLE.
  - 01 in COMM_F or WAIT_F.
  - 10 in COMM_T or WAIT_T.
  - 11 in BUF_EMPTY.
- `word_cnt`:
  - Clears to 0 on the IDLE→COMM_x transition.
  - Increments by 1 on every cycle with `data_1_en`=1.
  - Wraps 0xFFFF→0x0000.
  - Holds through WAIT, BUF_EMPTY and IDLE.

## Timing
- Reset is asynchronous. While `rst`=1, every register is 0: `state`=IDLE, `data_1_en`=0, `data_1`=0, `word_cnt`=0, all `_q`=0.
  - Consequently `f_en`, `t_en` and `modules` are also 0.
  - Asserting `rst` mid-session aborts immediately. No drain occurs and any in-flight strobe is lost.
- Button to state: a button rising in cycle n makes `state` change at edge n+1. The enable is active in cycle n+1.
- Generator word to write: valid in cycle k produces `data_1_en`/`data_1` in cycle k+1 (1 cycle latency).
- Full throttle: when full rises in cycle k, `f_en`/`t_en` are 0 in cycle k and no strobe appears in k+1. A strobe already in flight from k-1 still appears in cycle k.
- Drain exit: when `buffer_empty` is 1 and `data_2_valid` is 0 in cycle k, the state is IDLE at k+1.

## Test plan
- Reset, then start_f held high for 10 cycles → `state`=1 for exactly one transition, `modules`=01, `f_en`=1. Fibonacci words 1,1,2,3 appear on `data_1` one cycle after each `f_valid`, and `word_cnt` counts 4.
- start_f and start_t pulsed in the same cycle → COMM_F chosen, `t_en` stays 0 throughout.
- In COMM_T, force `buffer_full`=1 for 5 cycles → `t_en`=0 in the same cycle, `state`=5, no `data_1_en`. Full drops → back to state 2 and writes resume.
- stop_f_t and buffer_full rise in the same cycle in COMM_F → `state`=3, `modules`=11. Stays there while `data_2_valid`=1. `buffer_empty`=1 with `data_2_valid`=0 → IDLE next cycle, `modules`=00.
- Preload `word_cnt` to 0xFFFE via 65534 writes, then 2 more writes → `word_cnt`=0x0000. A new start clears it to 0.
- Assert `rst` asynchronously mid-cycle in WAIT_F → all outputs 0 immediately without a clock edge. After release, state is IDLE and a stop pulse has no effect.
